// File: rtl/photo_int_cntr_mc_if.sv
// AXI4-Lite register-access bundle for the photo-interrupter counter.
// Master drives address/data/valids; slave returns readies, responses and read data.
interface photo_int_cntr_mc_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/photo_int_cntr_mc.sv
// Multi-channel photo-interrupter edge counter: sync -> debounce -> edge count, threshold irq.
// Latency pin->COUNT = 3 + DEBOUNCE_CYC cycles; AXI accepts one write and one read at a time.
module photo_int_cntr_mc #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int DEBOUNCE_CYC = 16,
  parameter int EDGE_MODE    = 0,
  parameter int ADDR_W       = 6
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] photo_in_i,
  output logic              irq_o,
  photo_int_cntr_mc_if.slave s_axi
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_PEND   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_IRQEN  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_THRESH = IDX_W'(3);

  logic [NUM_CH-1:0] sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  logic [DB_W-1:0]   db_cnt_q [NUM_CH];
  logic [DB_W-1:0]   db_cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, pend_q, pend_d, irq_en_q, irq_en_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              irq_q, wr_rdy_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]       rdata_q, rd_word, thr_merged;
  logic [NUM_CH-1:0] rise, fall, edge_v, clr_v;
  logic              wr_fire, rd_fire;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              unused_ok;

  assign rise    = filt_q & ~filt_prev_q;
  assign fall    = ~filt_q & filt_prev_q;
  assign edge_v  = (EDGE_MODE == 0) ? rise : (EDGE_MODE == 1) ? fall : (rise | fall);
  assign wr_fire = wr_rdy_q & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire = arready_q & s_axi.arvalid;
  assign wr_idx  = s_axi.awaddr[ADDR_W-1:2];
  assign rd_idx  = s_axi.araddr[ADDR_W-1:2];
  // Clear bits are pure strobes: they act on the write cycle and are never stored.
  assign clr_v   = (wr_fire && wr_idx == IDX_CTRL && s_axi.wstrb[1]) ?
                   s_axi.wdata[8 +: NUM_CH] : '0;

  assign s_axi.awready = wr_rdy_q;
  assign s_axi.wready  = wr_rdy_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign irq_o         = irq_q;
  assign unused_ok     = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wdata};

  always_comb begin
    filt_d = filt_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      db_cnt_d[ch] = '0;
      if (sync2_q[ch] != filt_q[ch]) begin
        if (db_cnt_q[ch] == DB_LAST) filt_d[ch] = ~filt_q[ch];
        else                         db_cnt_d[ch] = db_cnt_q[ch] + 1'b1;
      end
    end
  end

  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    pend_d     = pend_q;
    thresh_d   = thresh_q;
    thr_merged = 32'(thresh_q);
    for (int b = 0; b < 4; b++) begin
      if (s_axi.wstrb[b]) thr_merged[8*b +: 8] = s_axi.wdata[8*b +: 8];
    end
    if (wr_fire) begin
      if (wr_idx == IDX_CTRL  && s_axi.wstrb[0]) en_d     = s_axi.wdata[NUM_CH-1:0];
      if (wr_idx == IDX_PEND  && s_axi.wstrb[0]) pend_d   = pend_q & ~s_axi.wdata[NUM_CH-1:0];
      if (wr_idx == IDX_IRQEN && s_axi.wstrb[0]) irq_en_d = s_axi.wdata[NUM_CH-1:0];
      if (wr_idx == IDX_THRESH)                  thresh_d = thr_merged[CNT_W-1:0];
    end
    // Threshold hits are applied after W1C so a same-cycle set survives the clear.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (clr_v[ch]) begin
        cnt_d[ch] = '0;
      end else if (en_q[ch] && edge_v[ch]) begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
        if (thresh_q != '0 && cnt_d[ch] == thresh_q) pend_d[ch] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if      (rd_idx == IDX_CTRL)   rd_word[NUM_CH-1:0] = en_q;
    else if (rd_idx == IDX_PEND)   rd_word[NUM_CH-1:0] = pend_q;
    else if (rd_idx == IDX_IRQEN)  rd_word[NUM_CH-1:0] = irq_en_q;
    else if (rd_idx == IDX_THRESH) rd_word[CNT_W-1:0]  = thresh_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_idx == IDX_W'(4 + ch)) rd_word[CNT_W-1:0] = cnt_q[ch];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        db_cnt_q[ch] <= '0;
        cnt_q[ch]    <= '0;
      end
      en_q      <= '0;
      pend_q    <= '0;
      irq_en_q  <= '0;
      thresh_q  <= '0;
      irq_q     <= 1'b0;
      wr_rdy_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q     <= photo_in_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        db_cnt_q[ch] <= db_cnt_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
      end
      en_q     <= en_d;
      pend_q   <= pend_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= |(pend_q & irq_en_q);

      wr_rdy_q <= !wr_rdy_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
      if (wr_fire)            bvalid_q <= 1'b1;
      else if (s_axi.bready)  bvalid_q <= 1'b0;

      arready_q <= !arready_q && s_axi.arvalid && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_photo_int_cntr_mc.sv
// Scoreboarded bench: dut0 (rising edges, 4-bit counters), dut1 (both edges, 32-bit).
// Read responses are checked by a monitor against expectations queued at issue time.
module tb_photo_int_cntr_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ph0 = '0, ph1 = '0;
  logic irq0, irq1;
  logic sel = 1'b0;

  logic [5:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  photo_int_cntr_mc_if #(.ADDR_W(6)) ax0();
  photo_int_cntr_mc_if #(.ADDR_W(6)) ax1();

  photo_int_cntr_mc #(.NUM_CH(4), .CNT_W(4), .DEBOUNCE_CYC(4), .EDGE_MODE(0), .ADDR_W(6)) dut0 (
    .clock_i(clk), .reset_i(rst), .photo_in_i(ph0), .irq_o(irq0), .s_axi(ax0));
  photo_int_cntr_mc #(.NUM_CH(4), .CNT_W(32), .DEBOUNCE_CYC(4), .EDGE_MODE(2), .ADDR_W(6)) dut1 (
    .clock_i(clk), .reset_i(rst), .photo_in_i(ph1), .irq_o(irq1), .s_axi(ax1));

  assign ax0.awaddr = awaddr;  assign ax1.awaddr = awaddr;
  assign ax0.wdata  = wdata;   assign ax1.wdata  = wdata;
  assign ax0.wstrb  = wstrb;   assign ax1.wstrb  = wstrb;
  assign ax0.araddr = araddr;  assign ax1.araddr = araddr;
  assign ax0.awvalid = awvalid & ~sel;  assign ax1.awvalid = awvalid & sel;
  assign ax0.wvalid  = wvalid & ~sel;   assign ax1.wvalid  = wvalid & sel;
  assign ax0.bready  = bready & ~sel;   assign ax1.bready  = bready & sel;
  assign ax0.arvalid = arvalid & ~sel;  assign ax1.arvalid = arvalid & sel;
  assign ax0.rready  = rready & ~sel;   assign ax1.rready  = rready & sel;

  logic awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [1:0]  bresp_m, rresp_m;
  logic [31:0] rdata_m;
  assign awready_m = sel ? ax1.awready : ax0.awready;
  assign wready_m  = sel ? ax1.wready  : ax0.wready;
  assign bvalid_m  = sel ? ax1.bvalid  : ax0.bvalid;
  assign bresp_m   = sel ? ax1.bresp   : ax0.bresp;
  assign arready_m = sel ? ax1.arready : ax0.arready;
  assign rvalid_m  = sel ? ax1.rvalid  : ax0.rvalid;
  assign rdata_m   = sel ? ax1.rdata   : ax0.rdata;
  assign rresp_m   = sel ? ax1.rresp   : ax0.rresp;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake timeout at %0t", nm, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rvalid_m && rready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_rvalid");
      end else begin
        chk("rdata", rdata_m, exp_q.pop_front());
        chk("rresp", 32'(rresp_m), 32'd0);
      end
    end
    if (bvalid_m && bready) chk("bresp", 32'(bresp_m), 32'd0);
  end

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    araddr = a;
    arvalid = 1'b1;
    while (!arready_m && n < 16) begin tick(1); n++; end
    if (!arready_m) timeout("arready");
    tick(1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid_m && n < 16) begin tick(1); n++; end
    if (!rvalid_m) timeout("rvalid");
    tick(1);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1;
    for (int i = 0; i < lead; i++) begin
      tick(1);
      chk("early_aw_w_ready", {30'd0, awready_m, wready_m}, 32'd0);
    end
    wvalid = 1'b1;
    while (!awready_m && n < 16) begin tick(1); n++; end
    if (!awready_m) timeout("awready");
    tick(1);
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid_m && n < 16) begin tick(1); n++; end
    if (!bvalid_m) timeout("bvalid");
    for (int i = 0; i < bdly; i++) begin
      tick(1);
      chk("bvalid_hold", 32'(bvalid_m), 32'd1);
    end
    bready = 1'b1;
    tick(1);
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid_m), 32'd0);
  endtask

  task automatic set_ph(input int ch, input logic v);
    if (sel) ph1[ch] = v;
    else     ph0[ch] = v;
  endtask

  task automatic pulse(input int ch, input int n, input int hi, input int lo);
    repeat (n) begin
      set_ph(ch, 1'b1); tick(hi);
      set_ph(ch, 1'b0); tick(lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b0;
    chk("rst_irq", {30'd0, irq1, irq0}, 32'd0);
    chk("rst_ready", {28'd0, awready_m, wready_m, arready_m, bvalid_m}, 32'd0);
    chk("rst_rvalid", 32'(rvalid_m), 32'd0);
    for (int a = 0; a < 8; a++) axi_read(6'(4 * a), 32'd0);

    // dut0: 3-cycle glitch is rejected, then 5 pulses each counted 7 cycles after the rise
    axi_write(6'h00, 32'h1, 4'hF, 0, 0);
    set_ph(0, 1'b1); tick(3); set_ph(0, 1'b0); tick(12);
    axi_read(6'h10, 32'd0);
    for (int p = 0; p < 5; p++) begin
      set_ph(0, 1'b1); tick(6);
      chk("cnt0_before_7", 32'(dut0.cnt_q[0]), 32'(p));
      set_ph(0, 1'b0); tick(1);
      chk("cnt0_at_7", 32'(dut0.cnt_q[0]), 32'(p + 1));
      tick(5);
    end
    axi_read(6'h10, 32'd5);

    // threshold interrupt on ch1 and W1C
    axi_write(6'h0C, 32'd3, 4'hF, 0, 0);
    axi_write(6'h08, 32'h2, 4'hF, 0, 0);
    axi_write(6'h00, 32'h2, 4'hF, 0, 0);
    pulse(1, 2, 6, 6); tick(4);
    axi_read(6'h04, 32'h0);
    pulse(1, 1, 6, 6); tick(4);
    axi_read(6'h04, 32'h2);
    axi_read(6'h14, 32'd3);
    chk("irq_set", 32'(irq0), 32'd1);
    axi_write(6'h04, 32'h2, 4'hF, 0, 0);
    chk("irq_clear", 32'(irq0), 32'd0);
    axi_read(6'h04, 32'h0);

    // 4-bit wrap on ch2; PEND[2] set but masked from irq
    axi_write(6'h00, 32'h4, 4'hF, 0, 0);
    pulse(2, 17, 6, 6); tick(6);
    axi_read(6'h18, 32'd1);
    axi_read(6'h04, 32'h4);
    chk("irq_masked", 32'(irq0), 32'd0);
    // write handshake lands on the increment cycle: clear wins
    set_ph(2, 1'b1); tick(5);
    axi_write(6'h00, 32'h404, 4'h3, 0, 0);
    set_ph(2, 1'b0); tick(12);
    axi_read(6'h18, 32'd0);
    axi_read(6'h00, 32'h4);

    // slow master, unmapped address
    axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 5, 4);
    axi_read(6'h3C, 32'd0);
    axi_read(6'h20, 32'd0);
    axi_read(6'h00, 32'h4);

    // dut1: both edges counted, disabled channel holds, filtering keeps tracking
    sel = 1'b1;
    axi_write(6'h00, 32'h8, 4'hF, 0, 0);
    pulse(3, 3, 6, 6); tick(6);
    axi_read(6'h1C, 32'd6);
    axi_write(6'h00, 32'h0, 4'hF, 0, 0);
    pulse(3, 2, 6, 6); tick(6);
    axi_read(6'h1C, 32'd6);
    axi_write(6'h00, 32'h8, 4'hF, 0, 0);
    pulse(3, 1, 6, 6); tick(6);
    axi_read(6'h1C, 32'd8);
    axi_write(6'h0C, 32'hAABB_CCDD, 4'b0101, 5, 4);
    axi_read(6'h0C, 32'h00BB_00DD);
    chk("irq1_idle", 32'(irq1), 32'd0);

    tick(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
